ex_mem: RTL and testbench

//  EX->MEM pipeline register. Registers EX results (dest reg, write enable/data, aluop, load/store addr+data, HI/LO)

---
 rtl/ex_mem_if.sv | 61 ++++++
 rtl/ex_mem.sv | 91 +++++++++
 tb/tb_ex_mem.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_if.sv
// EX->MEM pipeline register bus: stall/flush control, EX-side inputs and MEM-side outputs.
// Optional HI/LO pipelining signals exist only when EX_MEM_HILO_EN is defined.
interface ex_mem_if #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int ALUOP_W = 8
);
   logic [5:0]          stall;
   logic                flush;
   logic [RADDR_W-1:0]  ex_wd;
   logic                ex_wreg;
   logic [DATA_W-1:0]   ex_wdata;
   logic [ALUOP_W-1:0]  ex_aluop;
   logic [DATA_W-1:0]   ex_mem_addr;
   logic [DATA_W-1:0]   ex_reg2;
   logic [2*DATA_W-1:0] hilo_i;
   logic [1:0]          cnt_i;
   logic [RADDR_W-1:0]  mem_wd;
   logic                mem_wreg;
   logic [DATA_W-1:0]   mem_wdata;
   logic [ALUOP_W-1:0]  mem_aluop;
   logic [DATA_W-1:0]   mem_mem_addr;
   logic [DATA_W-1:0]   mem_reg2;
   logic                mem_valid;
   logic [2*DATA_W-1:0] hilo_o;
   logic [1:0]          cnt_o;
`ifdef EX_MEM_HILO_EN
   logic [DATA_W-1:0]   ex_hi;
   logic [DATA_W-1:0]   ex_lo;
   logic                ex_whilo;
   logic [DATA_W-1:0]   mem_hi;
   logic [DATA_W-1:0]   mem_lo;
   logic                mem_whilo;

   modport master (
      output stall, flush, ex_wd, ex_wreg, ex_wdata, ex_aluop, ex_mem_addr, ex_reg2,
             hilo_i, cnt_i, ex_hi, ex_lo, ex_whilo,
      input  mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_mem_addr, mem_reg2,
             mem_valid, hilo_o, cnt_o, mem_hi, mem_lo, mem_whilo
   );
   modport slave (
      input  stall, flush, ex_wd, ex_wreg, ex_wdata, ex_aluop, ex_mem_addr, ex_reg2,
             hilo_i, cnt_i, ex_hi, ex_lo, ex_whilo,
      output mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_mem_addr, mem_reg2,
             mem_valid, hilo_o, cnt_o, mem_hi, mem_lo, mem_whilo
   );
`else
   modport master (
      output stall, flush, ex_wd, ex_wreg, ex_wdata, ex_aluop, ex_mem_addr, ex_reg2,
             hilo_i, cnt_i,
      input  mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_mem_addr, mem_reg2,
             mem_valid, hilo_o, cnt_o
   );
   modport slave (
      input  stall, flush, ex_wd, ex_wreg, ex_wdata, ex_aluop, ex_mem_addr, ex_reg2,
             hilo_i, cnt_i,
      output mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_mem_addr, mem_reg2,
             mem_valid, hilo_o, cnt_o
   );
`endif
endinterface

// File: rtl/ex_mem.sv
// EX->MEM pipeline register with stall/flush handling and MADD/MSUB partial-product feedback.
// Optional EX_MEM_HILO_EN adds pipelined HI/LO write fields.
module ex_mem #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int ALUOP_W = 8
) (
   input logic     clk,
   input logic     rst,
   ex_mem_if.slave bus
);

   // A zero payload is the bubble: NOP register address, write disabled, not valid.
   typedef struct packed {
      logic [RADDR_W-1:0] wd;
      logic               wreg;
      logic [DATA_W-1:0]  wdata;
      logic [ALUOP_W-1:0] aluop;
      logic [DATA_W-1:0]  mem_addr;
      logic [DATA_W-1:0]  reg2;
`ifdef EX_MEM_HILO_EN
      logic [DATA_W-1:0]  hi;
      logic [DATA_W-1:0]  lo;
      logic               whilo;
`endif
      logic               valid;
   } stage_t;

   stage_t              ex_s;
   stage_t              mem_q;
   logic [2*DATA_W-1:0] hilo_q;
   logic [1:0]          cnt_q;

   // Only the EX and MEM bits of the stall vector matter here.
   logic unused_stall;
   assign unused_stall = ^{bus.stall[5], bus.stall[2:0]};

   // NOTE: default the whole struct first so no field can infer a latch.
   always_comb begin
      ex_s          = '0;
      ex_s.wd       = bus.ex_wd;
      ex_s.wreg     = bus.ex_wreg;
      ex_s.wdata    = bus.ex_wdata;
      ex_s.aluop    = bus.ex_aluop;
      ex_s.mem_addr = bus.ex_mem_addr;
      ex_s.reg2     = bus.ex_reg2;
`ifdef EX_MEM_HILO_EN
      ex_s.hi       = bus.ex_hi;
      ex_s.lo       = bus.ex_lo;
      ex_s.whilo    = bus.ex_whilo;
`endif
      ex_s.valid    = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         mem_q  <= '0;
         hilo_q <= '0;
         cnt_q  <= '0;
      end else if (bus.stall[4]) begin
         // MEM stopped (also covers the illegal EX-go/MEM-stop case): hold payload.
         hilo_q <= bus.hilo_i;
         cnt_q  <= bus.cnt_i;
      end else if (bus.stall[3]) begin
         mem_q  <= '0;
         hilo_q <= bus.hilo_i;
         cnt_q  <= bus.cnt_i;
      end else begin
         mem_q  <= ex_s;
         hilo_q <= '0;
         cnt_q  <= '0;
      end
   end

   assign bus.mem_wd       = mem_q.wd;
   assign bus.mem_wreg     = mem_q.wreg;
   assign bus.mem_wdata    = mem_q.wdata;
   assign bus.mem_aluop    = mem_q.aluop;
   assign bus.mem_mem_addr = mem_q.mem_addr;
   assign bus.mem_reg2     = mem_q.reg2;
   assign bus.mem_valid    = mem_q.valid;
   assign bus.hilo_o       = hilo_q;
   assign bus.cnt_o        = cnt_q;
`ifdef EX_MEM_HILO_EN
   assign bus.mem_hi       = mem_q.hi;
   assign bus.mem_lo       = mem_q.lo;
   assign bus.mem_whilo    = mem_q.whilo;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Scoreboard bench for ex_mem: driver pushes model results, monitor pops and compares after each edge.
// Works with and without EX_MEM_HILO_EN.
module tb_ex_mem;

   typedef struct {
      bit          rst;
      bit          flush;
      bit [5:0]    stall;
      bit [4:0]    wd;
      bit          wreg;
      bit [31:0]   wdata;
      bit [7:0]    aluop;
      bit [31:0]   addr;
      bit [31:0]   reg2;
      bit [63:0]   hilo;
      bit [1:0]    cnt;
      bit [31:0]   hi;
      bit [31:0]   lo;
      bit          whilo;
   } stim_t;

   typedef struct {
      bit [4:0]    wd;
      bit          wreg;
      bit [31:0]   wdata;
      bit [7:0]    aluop;
      bit [31:0]   addr;
      bit [31:0]   reg2;
      bit          valid;
      bit [63:0]   hilo;
      bit [1:0]    cnt;
      bit [31:0]   hi;
      bit [31:0]   lo;
      bit          whilo;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   bit   drive_done = 0;
   exp_t model_q;
   exp_t sb[$];

   always #5 clk = ~clk;

   ex_mem_if #(.DATA_W(32), .RADDR_W(5), .ALUOP_W(8)) bus ();
   ex_mem #(.DATA_W(32), .RADDR_W(5), .ALUOP_W(8)) u_dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference behaviour: what MEM should hold after an edge, given its previous contents.
   function automatic exp_t model(exp_t prev, stim_t s);
      exp_t n = prev;
      exp_t z = '{default: 0};
      if (s.rst || s.flush) begin
         n = z;
      end else if (s.stall[3] && !s.stall[4]) begin
         n = z;
         n.hilo = s.hilo;
         n.cnt  = s.cnt;
      end else if (s.stall[4]) begin
         n.hilo = s.hilo;
         n.cnt  = s.cnt;
      end else begin
         n = '{wd: s.wd, wreg: s.wreg, wdata: s.wdata, aluop: s.aluop, addr: s.addr,
               reg2: s.reg2, valid: 1, hilo: 0, cnt: 0, hi: s.hi, lo: s.lo, whilo: s.whilo};
      end
      return n;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      bit [5:0] pats [5] = '{6'b000000, 6'b001111, 6'b011111, 6'b010000, 6'b000111};
      s.rst   = ($urandom_range(49) == 0);
      s.flush = ($urandom_range(19) == 0);
      s.stall = pats[$urandom_range(4)];
      s.wd    = 5'($urandom);
      s.wreg  = 1'($urandom);
      s.wdata = $urandom;
      s.aluop = 8'($urandom);
      s.addr  = $urandom;
      s.reg2  = $urandom;
      s.hilo  = {$urandom, $urandom};
      s.cnt   = 2'($urandom_range(2));
      s.hi    = $urandom;
      s.lo    = $urandom;
      s.whilo = 1'($urandom);
      return s;
   endfunction

   function automatic stim_t base_stim();
      stim_t s = '{default: 0};
      return s;
   endfunction

   task automatic apply(input stim_t s);
      @(negedge clk);
      rst              = s.rst;
      bus.flush        = s.flush;
      bus.stall        = s.stall;
      bus.ex_wd        = s.wd;
      bus.ex_wreg      = s.wreg;
      bus.ex_wdata     = s.wdata;
      bus.ex_aluop     = s.aluop;
      bus.ex_mem_addr  = s.addr;
      bus.ex_reg2      = s.reg2;
      bus.hilo_i       = s.hilo;
      bus.cnt_i        = s.cnt;
`ifdef EX_MEM_HILO_EN
      bus.ex_hi        = s.hi;
      bus.ex_lo        = s.lo;
      bus.ex_whilo     = s.whilo;
`endif
      model_q = model(model_q, s);
      sb.push_back(model_q);
   endtask

   // Monitor: one result per edge, compared one time unit after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("mem_wd",       64'(bus.mem_wd),       64'(e.wd));
            check("mem_wreg",     64'(bus.mem_wreg),     64'(e.wreg));
            check("mem_wdata",    64'(bus.mem_wdata),    64'(e.wdata));
            check("mem_aluop",    64'(bus.mem_aluop),    64'(e.aluop));
            check("mem_mem_addr", 64'(bus.mem_mem_addr), 64'(e.addr));
            check("mem_reg2",     64'(bus.mem_reg2),     64'(e.reg2));
            check("mem_valid",    64'(bus.mem_valid),    64'(e.valid));
            check("hilo_o",       bus.hilo_o,            e.hilo);
            check("cnt_o",        64'(bus.cnt_o),        64'(e.cnt));
`ifdef EX_MEM_HILO_EN
            check("mem_hi",       64'(bus.mem_hi),       64'(e.hi));
            check("mem_lo",       64'(bus.mem_lo),       64'(e.lo));
            check("mem_whilo",    64'(bus.mem_whilo),    64'(e.whilo));
`endif
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      stim_t s;
      model_q = '{default: 0};

      // Reset held two cycles with busy EX inputs, then released.
      for (int i = 0; i < 2; i++) begin
         s = rand_stim();
         s.rst = 1; s.flush = 0; s.stall = 6'b000000; s.wreg = 1; s.wdata = 32'hFFFF_0000;
         apply(s);
      end
      s = rand_stim(); s.rst = 0; s.flush = 0; s.stall = 0; s.wdata = 32'h0BAD_F00D;
      apply(s);

      // Plain advance.
      s = base_stim(); s.wd = 5; s.wreg = 1; s.wdata = 32'h1234_5678; s.aluop = 8'h21;
      apply(s);

      // EX stalled, MEM free: bubble plus partial-product capture, then resume.
      s = base_stim(); s.stall = 6'b001111; s.hilo = 64'h00000001_00000002; s.cnt = 1;
      s.wd = 7; s.wreg = 1; s.wdata = 32'h7777_7777;
      apply(s);
      s = base_stim(); s.wd = 9; s.wreg = 1; s.wdata = 32'h9999_0000; s.hilo = 64'h55; s.cnt = 2;
      apply(s);

      // Load a value then hold with MEM stalled for three cycles.
      s = base_stim(); s.wd = 3; s.wreg = 1; s.wdata = 32'hA5A5_A5A5; s.addr = 32'h100;
      apply(s);
      for (int i = 0; i < 3; i++) begin
         s = rand_stim(); s.rst = 0; s.flush = 0; s.stall = 6'b011111; s.cnt = 2'(i);
         apply(s);
      end

      // Flush with a valid instruction, then flush and reset together.
      s = rand_stim(); s.rst = 0; s.flush = 1; s.stall = 0; s.wreg = 1; s.cnt = 2;
      apply(s);
      s = rand_stim(); s.rst = 0; s.flush = 0; s.stall = 0;
      apply(s);
      s = rand_stim(); s.rst = 1; s.flush = 1; s.stall = 6'b011111;
      apply(s);

      // HI/LO fields follow then bubble.
      s = base_stim(); s.whilo = 1; s.hi = 32'hDEAD; s.lo = 32'hBEEF; s.wd = 1;
      apply(s);
      s = base_stim(); s.stall = 6'b001111; s.whilo = 1; s.hi = 32'h1; s.lo = 32'h2;
      apply(s);

      // Randomized traffic, including the illegal EX-go/MEM-stop pattern.
      for (int i = 0; i < 400; i++) begin
         apply(rand_stim());
      end

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      drive_done = 1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
